ipg_slot_arbiter: RTL and testbench

IPG_SLOT_ARBITER -- requirements
Module: ipg_slot_arbiter

---
 rtl/ipg_slot_arbiter_pkg.sv | 7 +
 rtl/ipg_slot_rr_pick.sv | 11 +
 rtl/ipg_slot_arbiter.sv | 110 +++++++++++
 tb/tb_ipg_slot_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipg_slot_arbiter_pkg.sv
// ipg_slot_arbiter_pkg: shared state encoding, source ids and counter width for the slot arbiter.
package ipg_slot_arbiter_pkg;
  typedef enum logic [2:0] {IDLE = 3'b001, GRANT0 = 3'b010, GRANT1 = 3'b100} state_e;
  localparam logic SRC_REQ = 1'b0;
  localparam logic SRC_RESP = 1'b1;
  localparam int MSG_COUNT_WIDTH = 16;
endpackage

// File: rtl/ipg_slot_rr_pick.sv
// ipg_slot_rr_pick: two-input round-robin picker; rr_ptr breaks ties, a lone requester always wins.
module ipg_slot_rr_pick
  import ipg_slot_arbiter_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic rr_ptr_i,
  output logic grant_o
);
  assign grant_o = (valid0_i && valid1_i) ? rr_ptr_i : (valid1_i ? SRC_RESP : SRC_REQ);
endmodule

// File: rtl/ipg_slot_arbiter.sv
// ipg_slot_arbiter: packs two message streams into PHY idle slots, one whole message at a time.
module ipg_slot_arbiter
  import ipg_slot_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                       tx_clk,
  input  logic                       tx_rst,
  input  logic                       slot_avail,
  input  logic [DATA_WIDTH-1:0]      s0_tdata,
  input  logic                       s0_tvalid,
  input  logic                       s0_tlast,
  output logic                       s0_tready,
  input  logic [DATA_WIDTH-1:0]      s1_tdata,
  input  logic                       s1_tvalid,
  input  logic                       s1_tlast,
  output logic                       s1_tready,
  output logic [DATA_WIDTH-1:0]      m_slot_data,
  output logic                       m_slot_valid,
  output logic                       m_slot_src,
  output logic                       m_slot_first,
  output logic                       m_slot_last,
  output logic                       m_slot_abort,
  output logic [MSG_COUNT_WIDTH-1:0] msg_count0,
  output logic [MSG_COUNT_WIDTH-1:0] msg_count1
);
  state_e state_q, state_d;
  logic rr_q, rr_d, started_q, started_d, pick, src, tvalid, tlast, xfer, idle_cyc, timeout;
  logic [4:0] gap_q, gap_d;
  logic [MSG_COUNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [DATA_WIDTH-1:0] tdata;
  ipg_slot_rr_pick u_pick (
    .valid0_i(s0_tvalid),
    .valid1_i(s1_tvalid),
    .rr_ptr_i(rr_q),
    .grant_o (pick)
  );
  assign src        = state_q == GRANT1;
  assign s0_tready  = !tx_rst && state_q == GRANT0 && slot_avail;
  assign s1_tready  = !tx_rst && state_q == GRANT1 && slot_avail;
  assign tvalid     = src ? s1_tvalid : s0_tvalid;
  assign tlast      = src ? s1_tlast : s0_tlast;
  assign tdata      = src ? s1_tdata : s0_tdata;
  assign xfer       = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);
  // Only source silence after a started message counts; stalls and unstarted grants never do.
  assign idle_cyc   = state_q != IDLE && started_q && !tvalid && slot_avail;
  assign timeout    = idle_cyc && gap_q == 5'(GAP_TIMEOUT - 1);
  assign msg_count0 = cnt0_q;
  assign msg_count1 = cnt1_q;
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    started_d = started_q;
    gap_d     = gap_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (state_q == IDLE) begin
      started_d = 1'b0;
      gap_d     = '0;
      if (s0_tvalid || s1_tvalid) state_d = pick ? GRANT1 : GRANT0;
    end else if (xfer) begin
      started_d = 1'b1;
      gap_d     = '0;
      if (tlast) begin
        state_d = IDLE;
        rr_d    = !src;
        cnt0_d  = src ? cnt0_q : cnt0_q + MSG_COUNT_WIDTH'(1);
        cnt1_d  = src ? cnt1_q + MSG_COUNT_WIDTH'(1) : cnt1_q;
      end
    end else if (idle_cyc) begin
      gap_d = gap_q + 5'd1;
      if (timeout) begin
        state_d = IDLE;
        rr_d    = !src;
      end
    end
  end
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      started_q    <= 1'b0;
      gap_q        <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      m_slot_data  <= '0;
      m_slot_valid <= 1'b0;
      m_slot_src   <= 1'b0;
      m_slot_first <= 1'b0;
      m_slot_last  <= 1'b0;
      m_slot_abort <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      started_q    <= started_d;
      gap_q        <= gap_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      m_slot_valid <= xfer;
      m_slot_abort <= timeout;
      if (xfer) begin
        m_slot_data  <= tdata;
        m_slot_src   <= src;
        m_slot_first <= !started_q;
        m_slot_last  <= tlast;
      end
    end
  end
endmodule

// File: tb/tb_ipg_slot_arbiter.sv
// tb_ipg_slot_arbiter: scenario tasks driving both sources against a scoreboard of expected slot words.
module tb_ipg_slot_arbiter;
  typedef struct packed {
    logic [63:0] d;
    logic        s;
    logic        f;
    logic        l;
  } exp_t;
  logic tx_clk, tx_rst, slot_avail;
  logic [63:0] td[2];
  logic tv[2], tl[2];
  logic s0_tready, s1_tready;
  logic [63:0] m_slot_data;
  logic m_slot_valid, m_slot_src, m_slot_first, m_slot_last, m_slot_abort;
  logic [15:0] msg_count0, msg_count1;
  exp_t q[$];
  int checks = 0, passed = 0, aborts = 0;
  ipg_slot_arbiter dut (
    .tx_clk      (tx_clk),
    .tx_rst      (tx_rst),
    .slot_avail  (slot_avail),
    .s0_tdata    (td[0]),
    .s0_tvalid   (tv[0]),
    .s0_tlast    (tl[0]),
    .s0_tready   (s0_tready),
    .s1_tdata    (td[1]),
    .s1_tvalid   (tv[1]),
    .s1_tlast    (tl[1]),
    .s1_tready   (s1_tready),
    .m_slot_data (m_slot_data),
    .m_slot_valid(m_slot_valid),
    .m_slot_src  (m_slot_src),
    .m_slot_first(m_slot_first),
    .m_slot_last (m_slot_last),
    .m_slot_abort(m_slot_abort),
    .msg_count0  (msg_count0),
    .msg_count1  (msg_count1)
  );
  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;
  always @(negedge tx_clk) begin
    if (m_slot_abort) aborts++;
    if (!tx_rst && m_slot_valid) begin
      exp_t e;
      checks++;
      if (q.size() == 0) $display("FAIL sb_unexpected got data=%h src=%0d first=%0d last=%0d, required none", m_slot_data, m_slot_src, m_slot_first, m_slot_last);
      else begin
        e = q.pop_front();
        if ({m_slot_data, m_slot_src, m_slot_first, m_slot_last} !== e)
          $display("FAIL sb_word got data=%h src=%0d first=%0d last=%0d, required data=%h src=%0d first=%0d last=%0d", m_slot_data, m_slot_src, m_slot_first, m_slot_last, e.d, e.s, e.f, e.l);
        else passed++;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1);
  end
  function automatic void exp_msg(input int s, input logic [63:0] base, input logic [63:0] step, input int n, input bit wl);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = base + 64'(i) * step;
      e.s = s[0];
      e.f = (i == 0);
      e.l = wl && (i == n - 1);
      q.push_back(e);
    end
  endfunction
  task automatic align();
    @(negedge tx_clk);
    #2;
  endtask
  task automatic drive(input int s, input logic [63:0] base, input logic [63:0] step, input int n, input bit wl);
    int b;
    bit acc;
    for (int i = 0; i < n; i++) begin
      td[s] = base + 64'(i) * step;
      tl[s] = wl && (i == n - 1);
      tv[s] = 1'b1;
      b = 0;
      do begin
        acc = (s == 1) ? s1_tready : s0_tready;
        @(negedge tx_clk);
        #2;
        b++;
      end while (!acc && b < 300);
      if (!acc) begin
        checks++;
        $display("FAIL drive_timeout src=%0d word=%0d accepted=0 required=1", s, i);
        tv[s] = 1'b0;
        tl[s] = 1'b0;
        return;
      end
    end
    tv[s] = 1'b0;
    tl[s] = 1'b0;
  endtask
  task automatic wait_drain();
    int b = 0;
    while (q.size() != 0 && b < 100) begin
      @(negedge tx_clk);
      #2;
      b++;
    end
  endtask
  task automatic test_reset();
    tx_rst = 1'b1;
    slot_avail = 1'b1;
    tv[0] = 1'b1;
    tv[1] = 1'b1;
    tl[0] = 1'b0;
    tl[1] = 1'b0;
    td[0] = '1;
    td[1] = '1;
    repeat (3) @(negedge tx_clk);
    #3;
    checks++;
    if ({m_slot_valid, m_slot_first, m_slot_last, m_slot_abort, m_slot_src} !== 5'b0) $display("FAIL reset_flags got %b required 00000", {m_slot_valid, m_slot_first, m_slot_last, m_slot_abort, m_slot_src});
    else passed++;
    checks++;
    if (m_slot_data !== 64'h0) $display("FAIL reset_data got %h required 0", m_slot_data);
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== 32'h0) $display("FAIL reset_counts got %h/%h required 0/0", msg_count0, msg_count1);
    else passed++;
    checks++;
    if ({s0_tready, s1_tready} !== 2'b00) $display("FAIL reset_tready got %b required 00", {s0_tready, s1_tready});
    else passed++;
    tv[0] = 1'b0;
    tv[1] = 1'b0;
    align();
    tx_rst = 1'b0;
  endtask
  task automatic test_basic();
    logic [4:0] pat;
    exp_msg(0, 64'h11, 64'h11, 3, 1);
    align();
    fork
      drive(0, 64'h11, 64'h11, 3, 1);
      for (int k = 0; k < 5; k++) begin
        @(negedge tx_clk);
        #3;
        pat[k] = m_slot_valid;
      end
    join
    wait_drain();
    checks++;
    if (pat !== 5'b01110) $display("FAIL basic_valid_timing got %b required 01110", pat);
    else passed++;
    checks++;
    if (q.size() !== 0) $display("FAIL basic_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== {16'd1, 16'd0}) $display("FAIL basic_counts got %0d/%0d required 1/0", msg_count0, msg_count1);
    else passed++;
  endtask
  task automatic test_rr();
    exp_msg(1, 64'hB1, 64'h1, 1, 1);
    exp_msg(0, 64'hA1, 64'h1, 1, 1);
    align();
    fork
      drive(0, 64'hA1, 64'h1, 1, 1);
      drive(1, 64'hB1, 64'h1, 1, 1);
    join
    wait_drain();
    checks++;
    if (q.size() !== 0) $display("FAIL rr_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== {16'd2, 16'd1}) $display("FAIL rr_counts got %0d/%0d required 2/1", msg_count0, msg_count1);
    else passed++;
  endtask
  task automatic test_both();
    logic [6:0] pat;
    tx_rst = 1'b1;
    repeat (2) align();
    tx_rst = 1'b0;
    exp_msg(0, 64'hA0, 64'h1, 2, 1);
    exp_msg(1, 64'hB0, 64'h1, 2, 1);
    align();
    fork
      drive(0, 64'hA0, 64'h1, 2, 1);
      drive(1, 64'hB0, 64'h1, 2, 1);
      for (int k = 0; k < 7; k++) begin
        @(negedge tx_clk);
        #3;
        pat[k] = m_slot_valid;
      end
    join
    wait_drain();
    checks++;
    if (pat !== 7'b0110110) $display("FAIL both_valid_timing got %b required 0110110", pat);
    else passed++;
    checks++;
    if (q.size() !== 0) $display("FAIL both_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== {16'd1, 16'd1}) $display("FAIL both_counts got %0d/%0d required 1/1", msg_count0, msg_count1);
    else passed++;
  endtask
  task automatic test_avail();
    int rdy = 0, viol = 0, a0;
    bit done = 0, prev = 0;
    a0 = aborts;
    slot_avail = 1'b0;
    exp_msg(1, 64'hC0, 64'h1, 4, 1);
    align();
    fork
      begin
        drive(1, 64'hC0, 64'h1, 4, 1);
        done = 1;
      end
      begin
        repeat (20) @(negedge tx_clk);
        #1;
        slot_avail = 1'b1;
        while (!done) begin
          @(negedge tx_clk);
          #1;
          slot_avail = ~slot_avail;
        end
      end
      while (!done) begin
        @(negedge tx_clk);
        #3;
        if (tv[1]) begin
          if (s1_tready) rdy++;
          if (s1_tready !== slot_avail || s0_tready !== 1'b0) viol++;
        end
        if (m_slot_valid && !prev) viol++;
        prev = slot_avail;
      end
    join
    slot_avail = 1'b1;
    wait_drain();
    checks++;
    if (rdy !== 4) $display("FAIL avail_ready_cycles got %0d required 4", rdy);
    else passed++;
    checks++;
    if (viol !== 0) $display("FAIL avail_mirror got %0d violations required 0", viol);
    else passed++;
    checks++;
    if (aborts - a0 !== 0) $display("FAIL avail_abort got %0d pulses required 0", aborts - a0);
    else passed++;
    checks++;
    if (q.size() !== 0) $display("FAIL avail_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if (msg_count1 !== 16'd2) $display("FAIL avail_count1 got %0d required 2", msg_count1);
    else passed++;
  endtask
  task automatic test_abort();
    int at = 0, a0;
    a0 = aborts;
    exp_msg(0, 64'hD0, 64'h1, 1, 0);
    align();
    drive(0, 64'hD0, 64'h1, 1, 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge tx_clk);
      #3;
      if (m_slot_abort && at == 0) at = k;
    end
    checks++;
    if (at !== 16) $display("FAIL abort_cycle got %0d required 16", at);
    else passed++;
    checks++;
    if (aborts - a0 !== 1) $display("FAIL abort_pulses got %0d required 1", aborts - a0);
    else passed++;
    checks++;
    if (msg_count0 !== 16'd1) $display("FAIL abort_count0 got %0d required 1", msg_count0);
    else passed++;
    exp_msg(1, 64'hE1, 64'h1, 1, 1);
    exp_msg(0, 64'hE0, 64'h1, 1, 1);
    align();
    fork
      drive(0, 64'hE0, 64'h1, 1, 1);
      drive(1, 64'hE1, 64'h1, 1, 1);
    join
    wait_drain();
    checks++;
    if (q.size() !== 0) $display("FAIL abort_rr_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== {16'd2, 16'd3}) $display("FAIL abort_rr_counts got %0d/%0d required 2/3", msg_count0, msg_count1);
    else passed++;
  endtask
  task automatic test_rst_mid();
    int a0;
    exp_msg(0, 64'h40, 64'h1, 1, 0);
    align();
    td[0] = 64'h40;
    tl[0] = 1'b0;
    tv[0] = 1'b1;
    align();
    align();
    td[0] = 64'h41;
    tx_rst = 1'b1;
    a0 = aborts;
    @(negedge tx_clk);
    #3;
    checks++;
    if ({m_slot_valid, m_slot_first, m_slot_last, m_slot_abort, m_slot_src} !== 5'b0) $display("FAIL rstmid_flags got %b required 00000", {m_slot_valid, m_slot_first, m_slot_last, m_slot_abort, m_slot_src});
    else passed++;
    checks++;
    if (m_slot_data !== 64'h0) $display("FAIL rstmid_data got %h required 0", m_slot_data);
    else passed++;
    checks++;
    if ({msg_count0, msg_count1, s0_tready, s1_tready} !== 34'h0) $display("FAIL rstmid_counts_ready got %0d/%0d rdy=%b%b required 0/0 rdy=00", msg_count0, msg_count1, s0_tready, s1_tready);
    else passed++;
    tv[0] = 1'b0;
    tx_rst = 1'b0;
    repeat (20) @(negedge tx_clk);
    checks++;
    if (aborts - a0 !== 0) $display("FAIL rstmid_abort got %0d pulses required 0", aborts - a0);
    else passed++;
    checks++;
    if (q.size() !== 0) $display("FAIL rstmid_drain got %0d left required 0", q.size());
    else passed++;
    exp_msg(1, 64'hF0, 64'h1, 2, 1);
    align();
    drive(1, 64'hF0, 64'h1, 2, 1);
    wait_drain();
    checks++;
    if (q.size() !== 0) $display("FAIL rstmid_s1_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if ({msg_count0, msg_count1} !== {16'd0, 16'd1}) $display("FAIL rstmid_s1_counts got %0d/%0d required 0/1", msg_count0, msg_count1);
    else passed++;
  endtask
  task automatic test_wrap();
    @(negedge tx_clk);
    force dut.cnt1_q = 16'hFFFF;
    @(negedge tx_clk);
    release dut.cnt1_q;
    #3;
    checks++;
    if (msg_count1 !== 16'hFFFF) $display("FAIL wrap_preload got %h required ffff", msg_count1);
    else passed++;
    exp_msg(1, 64'h99, 64'h1, 1, 1);
    align();
    drive(1, 64'h99, 64'h1, 1, 1);
    wait_drain();
    checks++;
    if (q.size() !== 0) $display("FAIL wrap_drain got %0d left required 0", q.size());
    else passed++;
    checks++;
    if (msg_count1 !== 16'h0000) $display("FAIL wrap_count1 got %h required 0000", msg_count1);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_rr();
    test_both();
    test_avail();
    test_abort();
    test_rst_mid();
    test_wrap();
    repeat (3) @(negedge tx_clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
